// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and transfer status between a requester and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic cmd_valid;
  logic cmd_ready;
  logic busy;
  logic done;
  logic ack_err;
  logic timeout;
  modport master(output cmd_data, cmd_valid, input cmd_ready, busy, done, ack_err, timeout);
  modport slave(input cmd_data, cmd_valid, output cmd_ready, busy, done, ack_err, timeout);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device over open-drain PS/2 clock/data lines
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rstn,
  ps2_host_tx_if.slave cmd,
  input  logic ps2_c,
  input  logic ps2_d,
  output logic ps2_c_oe,
  output logic ps2_d_oe
);
  typedef enum logic [2:0] {IDLE, INHIBIT, START, DATA, ACK, WAIT_IDLE} state_t;
  state_t state, nxt;
  logic [1:0] c_s, d_s;
  logic c_q, par, bit_oe, fall_c, idle, tmo, tmo_exit;
  logic [20:0] cnt;
  logic [3:0] n;
  logic [7:0] dat;
  assign fall_c = c_q & ~c_s[1];
  assign idle = c_s[1] & d_s[1];
  assign tmo = cnt >= 21'(TIMEOUT_CYCLES - 1);
  assign tmo_exit = (state == DATA || state == ACK || state == WAIT_IDLE) && nxt == IDLE && !(state == WAIT_IDLE && idle);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      nxt = cmd.cmd_valid ? INHIBIT : IDLE;
      INHIBIT:   nxt = cnt == 21'(INHIBIT_CYCLES - 1) ? START : INHIBIT;
      START:     nxt = DATA;
      DATA:      nxt = fall_c && n == 4'd9 ? ACK : tmo ? IDLE : DATA;
      ACK:       nxt = fall_c ? WAIT_IDLE : tmo ? IDLE : ACK;
      WAIT_IDLE: nxt = idle || tmo ? IDLE : WAIT_IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    bit_oe = n == 4'd0 ? 1'b1 : n <= 4'd8 ? ~dat[3'(n - 4'd1)] : n == 4'd9 ? ~par : 1'b0;
    ps2_c_oe = state == INHIBIT || state == START;
    ps2_d_oe = state == START || (state == DATA && bit_oe);
    cmd.cmd_ready = state == IDLE;
    cmd.busy = state != IDLE;
  end
  // the single counter times the inhibit phase, then restarts at START as the saturating timeout
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      c_s <= 2'b11;
      d_s <= 2'b11;
      c_q <= 1'b1;
      cnt <= '0;
      n <= '0;
      dat <= '0;
      par <= 1'b0;
      cmd.done <= 1'b0;
      cmd.ack_err <= 1'b0;
      cmd.timeout <= 1'b0;
    end else begin
      c_s <= {c_s[0], ps2_c};
      d_s <= {d_s[0], ps2_d};
      c_q <= c_s[1];
      cnt <= state == IDLE || state == START ? '0 : cnt + {20'd0, cnt != '1};
      n <= state != DATA ? '0 : n + {3'd0, fall_c};
      cmd.done <= state != IDLE && nxt == IDLE;
      if (state == IDLE && cmd.cmd_valid) begin
        dat <= cmd.cmd_data;
        par <= ~^cmd.cmd_data;
        cmd.ack_err <= 1'b0;
        cmd.timeout <= 1'b0;
      end
      if (state == ACK && fall_c) cmd.ack_err <= d_s[1];
      if (tmo_exit) begin
        cmd.ack_err <= 1'b1;
        cmd.timeout <= 1'b1;
      end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed vectors against a PS/2 device model on scaled timing
module tb_ps2_host_tx;
  localparam int INH = 1200;
  localparam int TO = 5000;
  localparam int H = 40;
  typedef struct {
    logic [7:0] b;
    logic ack;
    logic par;
    logic ae;
  } vec_t;
  logic clk = 0, rstn = 0, dev_c = 1, dev_d = 1;
  logic ps2_c, ps2_d, ps2_c_oe, ps2_d_oe;
  int total = 0, bad = 0, ndone = 0;
  logic last_ae, last_to;
  logic [10:0] bits;
  vec_t tbl[5];
  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .cmd(bus), .ps2_c(ps2_c), .ps2_d(ps2_d),
    .ps2_c_oe(ps2_c_oe), .ps2_d_oe(ps2_d_oe)
  );
  assign ps2_c = ps2_c_oe ? 1'b0 : dev_c;
  assign ps2_d = ps2_d_oe ? 1'b0 : dev_d;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.done) begin
      ndone <= ndone + 1;
      last_ae <= bus.ack_err;
      last_to <= bus.timeout;
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [7:0] b);
    @(negedge clk);
    bus.cmd_data = b;
    bus.cmd_valid = 1;
    @(negedge clk);
    bus.cmd_valid = 0;
  endtask
  task automatic wait_start(output int inh);
    int g = 0;
    inh = 0;
    while (!ps2_c_oe && g < 100) begin g++; @(negedge clk); end
    while (ps2_c_oe && !ps2_d_oe && inh < 20000) begin inh++; @(negedge clk); end
    chk("start_bit", {30'd0, ps2_c_oe, ps2_d_oe}, 2'b11);
    @(negedge clk);
    chk("clk_release", {30'd0, ps2_c_oe, ps2_d_oe}, 2'b01);
  endtask
  task automatic dev_frame(input int nf, input logic ack, output logic [10:0] cap);
    cap = '1;
    for (int k = 0; k < nf; k++) begin
      repeat (H / 2) @(negedge clk);
      cap[k] = ps2_d;
      if (k == 10) dev_d = ~ack;
      repeat (H / 2) @(negedge clk);
      dev_c = 0;
      repeat (H) @(negedge clk);
      dev_c = 1;
    end
    if (nf == 11) begin
      repeat (H) @(negedge clk);
      dev_d = 1;
    end
  endtask
  task automatic wait_done(input int prev);
    int g = 0;
    while (ndone == prev && g < 20000) begin g++; @(negedge clk); end
    @(negedge clk);
    chk("done_count", ndone - prev, 1);
    chk("lines_free", {30'd0, ps2_c_oe, ps2_d_oe}, 0);
  endtask
  task automatic run_vec(input vec_t v);
    int inh, prev;
    prev = ndone;
    issue(v.b);
    wait_start(inh);
    chk("inhibit_len", inh, INH);
    dev_frame(11, v.ack, bits);
    wait_done(prev);
    chk("start_cap", {31'd0, bits[0]}, 0);
    chk("data_cap", {24'd0, bits[8:1]}, {24'd0, v.b});
    chk("par_cap", {31'd0, bits[9]}, {31'd0, v.par});
    chk("stop_cap", {31'd0, bits[10]}, 1);
    chk("ack_err", {31'd0, last_ae}, {31'd0, v.ae});
    chk("timeout", {31'd0, last_to}, 0);
  endtask
  initial begin
    int inh, prev, cyc, g, gap;
    tbl[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h5A, 1'b0, 1'b1, 1'b1};
    bus.cmd_data = 0;
    bus.cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_oe", {30'd0, ps2_c_oe, ps2_d_oe}, 0);
    chk("rst_status", {28'd0, bus.busy, bus.done, bus.ack_err, bus.timeout}, 0);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 1);
    rstn = 1;
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);
    prev = ndone;
    issue(8'h12);
    wait_start(inh);
    cyc = 0;
    while (ps2_d_oe && cyc < 6000) begin cyc++; @(negedge clk); end
    chk("to_len", cyc, TO);
    chk("to_flags", {28'd0, bus.done, bus.ack_err, bus.timeout, ps2_c_oe | ps2_d_oe}, 4'b1110);
    @(negedge clk);
    chk("to_count", ndone - prev, 1);
    prev = ndone;
    issue(8'h33);
    wait_start(inh);
    dev_frame(4, 1'b1, bits);
    chk("pre_rst_d", {31'd0, ps2_d_oe}, 1);
    #2 rstn = 0;
    #1 chk("async_rel", {30'd0, ps2_c_oe, ps2_d_oe}, 0);
    repeat (3) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("rst_ready2", {31'd0, bus.cmd_ready}, 1);
    chk("rst_nodone", ndone - prev, 0);
    run_vec('{8'hF4, 1'b1, 1'b0, 1'b0});
    prev = ndone;
    @(negedge clk);
    bus.cmd_data = 8'h55;
    bus.cmd_valid = 1;
    @(negedge clk);
    bus.cmd_data = 8'hAA;
    wait_start(inh);
    dev_frame(11, 1'b1, bits);
    chk("b2b_first", {24'd0, bits[8:1]}, 32'h55);
    g = 0;
    while (!bus.done && g < 2000) begin g++; @(negedge clk); end
    chk("b2b_done0", {31'd0, bus.done}, 1);
    gap = 0;
    while (!bus.busy && gap < 10) begin gap++; @(negedge clk); end
    chk("b2b_gap", gap, 1);
    bus.cmd_valid = 0;
    wait_start(inh);
    dev_frame(11, 1'b1, bits);
    chk("b2b_second", {24'd0, bits[8:1]}, 32'hAA);
    chk("b2b_par", {31'd0, bits[9]}, 1);
    wait_done(prev + 1);
    chk("b2b_total", ndone - prev, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
